// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the TinyMIPS multicycle controller, datapath and ALU decoder.
// The TRAP state exists only when ILLEGAL_TRAP_EN is defined.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [1:0] ALUSRCB_RD2  = 2'b00;
  localparam logic [1:0] ALUSRCB_ONE  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
  localparam logic [1:0] ALUSRCB_BOFF = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_LBRD, S_LBWR, S_SBWR,
    S_RTEX, S_RTWR, S_BEQEX, S_JEX, S_ADDIEX, S_ADDIWR
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  // pcwrite/branch are internal; the top folds them into pcen with the zero flag.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
// Outputs are Moore (registered state) except pcen, which also folds in zero.
interface mips_multicycle_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int OPBITS = 6
);
  import mips_multicycle_ctrl_pkg::*;

  logic [OPBITS-1:0]    op;
  logic                 zero;
  logic                 memread;
  logic                 memwrite;
  logic                 iord;
  logic [32/WIDTH-1:0]  irwrite;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           aluop;
  logic [1:0]           pcsource;
  logic                 pcen;
  logic                 regwrite;
  logic                 regdst;
  logic                 memtoreg;
  logic                 illegal;
  state_t               state;

  modport master (
    input  op, zero,
    output memread, memwrite, iord, irwrite, alusrca, alusrcb, aluop,
           pcsource, pcen, regwrite, regdst, memtoreg, illegal, state
  );

  modport slave (
    output op, zero,
    input  memread, memwrite, iord, irwrite, alusrca, alusrcb, aluop,
           pcsource, pcen, regwrite, regdst, memtoreg, illegal, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl_ctrl_out_decode.sv
// Pure combinational decode of registered state/beat into datapath controls.
// Reset gating and the pcen fold happen in the top.
module ctrl_out_decode
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int NBEAT = 4,
  parameter int BW    = 2
) (
  input  state_t           i_state,
  input  logic [BW-1:0]    i_beat,
  output ctrl_t            o_ctrl,
  output logic [NBEAT-1:0] o_irwrite
);

  always_comb begin
    o_ctrl    = '0;
    o_irwrite = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memread  = 1'b1;
        o_irwrite       = NBEAT'(1) << i_beat;
        o_ctrl.alusrcb  = ALUSRCB_ONE;
        o_ctrl.pcwrite  = 1'b1;
        o_ctrl.pcsource = PCSRC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alusrcb = ALUSRCB_BOFF;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_LBRD: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_LBWR: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      S_SBWR: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_RTEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_RD2;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTWR: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = 1'b1;
      end
      S_BEQEX: begin
        o_ctrl.alusrca  = 1'b1;
        o_ctrl.aluop    = ALUOP_SUB;
        o_ctrl.branch   = 1'b1;
        o_ctrl.pcsource = PCSRC_ALUOUT;
      end
      S_JEX: begin
        o_ctrl.pcwrite  = 1'b1;
        o_ctrl.pcsource = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWR: begin
        o_ctrl.regwrite = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        o_ctrl.illegal = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// TinyMIPS multicycle control FSM: beat-wise fetch, decode, execute, memory, write-back.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP (illegal=1) until reset.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int OPBITS = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam int NBEAT = 32 / WIDTH;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [BW-1:0]    r_beat;
  logic [BW-1:0]    w_beat_next;
  ctrl_t            w_ctrl;
  logic [NBEAT-1:0] w_irwrite;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      r_beat  <= w_beat_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_beat_next = r_beat;
    case (r_state)
      S_FETCH: begin
        // beat only returns to 0 on the way into DECODE
        if (r_beat == BW'(NBEAT - 1)) begin
          w_next      = S_DECODE;
          w_beat_next = '0;
        end else begin
          w_beat_next = r_beat + 1'b1;
        end
      end
      S_DECODE: begin
        if (bus.op == OPBITS'(OP_LB) || bus.op == OPBITS'(OP_SB)) w_next = S_MEMADR;
        else if (bus.op == OPBITS'(OP_RTYPE)) w_next = S_RTEX;
        else if (bus.op == OPBITS'(OP_BEQ))   w_next = S_BEQEX;
        else if (bus.op == OPBITS'(OP_J))     w_next = S_JEX;
        else if (bus.op == OPBITS'(OP_ADDI))  w_next = S_ADDIEX;
`ifdef ILLEGAL_TRAP_EN
        else w_next = S_TRAP;
`else
        else w_next = S_FETCH;
`endif
      end
      S_MEMADR: w_next = (bus.op == OPBITS'(OP_SB)) ? S_SBWR : S_LBRD;
      S_LBRD:   w_next = S_LBWR;
      S_RTEX:   w_next = S_RTWR;
      S_ADDIEX: w_next = S_ADDIWR;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  ctrl_out_decode #(.NBEAT(NBEAT), .BW(BW)) u_ctrl_out_decode (
    .i_state   (r_state),
    .i_beat    (r_beat),
    .o_ctrl    (w_ctrl),
    .o_irwrite (w_irwrite)
  );

  // While reset is high nothing may reach the datapath, even from a stale state.
  assign bus.memread  = ~reset & w_ctrl.memread;
  assign bus.memwrite = ~reset & w_ctrl.memwrite;
  assign bus.iord     = ~reset & w_ctrl.iord;
  assign bus.irwrite  = reset ? '0 : w_irwrite;
  assign bus.alusrca  = ~reset & w_ctrl.alusrca;
  assign bus.alusrcb  = reset ? 2'b00 : w_ctrl.alusrcb;
  assign bus.aluop    = reset ? 2'b00 : w_ctrl.aluop;
  assign bus.pcsource = reset ? 2'b00 : w_ctrl.pcsource;
  assign bus.pcen     = ~reset & (w_ctrl.pcwrite | (w_ctrl.branch & bus.zero));
  assign bus.regwrite = ~reset & w_ctrl.regwrite;
  assign bus.regdst   = ~reset & w_ctrl.regdst;
  assign bus.memtoreg = ~reset & w_ctrl.memtoreg;
  assign bus.illegal  = ~reset & w_ctrl.illegal;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl (WIDTH=8, four fetch beats).
// Per-cycle expected outputs come from a hand-built table plus reset/trap sequences.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
  } exp_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       zero;
    exp_t       exp;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];

  mips_multicycle_ctrl_if #(.WIDTH(8), .OPBITS(6)) bus ();

  mips_multicycle_ctrl #(.WIDTH(8), .OPBITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output words for each state, written straight from the state table.
  function automatic exp_t e_fetch(int b);
    exp_t e = '0;
    e.memread = 1'b1;
    e.irwrite = 4'b0001 << b;
    e.alusrcb = 2'b01;
    e.pcen    = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_dec();
    exp_t e = '0;
    e.alusrcb = 2'b11;
    return e;
  endfunction

  function automatic exp_t e_memadr();
    exp_t e = '0;
    e.alusrca = 1'b1;
    e.alusrcb = 2'b10;
    return e;
  endfunction

  function automatic exp_t e_lbrd();
    exp_t e = '0;
    e.memread = 1'b1;
    e.iord    = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_lbwr();
    exp_t e = '0;
    e.regwrite = 1'b1;
    e.memtoreg = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_sbwr();
    exp_t e = '0;
    e.memwrite = 1'b1;
    e.iord     = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_rtex();
    exp_t e = '0;
    e.alusrca = 1'b1;
    e.aluop   = 2'b10;
    return e;
  endfunction

  function automatic exp_t e_rtwr();
    exp_t e = '0;
    e.regwrite = 1'b1;
    e.regdst   = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_beqex(logic z);
    exp_t e = '0;
    e.alusrca  = 1'b1;
    e.aluop    = 2'b01;
    e.pcsource = 2'b01;
    e.pcen     = z;
    return e;
  endfunction

  function automatic exp_t e_jex();
    exp_t e = '0;
    e.pcen     = 1'b1;
    e.pcsource = 2'b10;
    return e;
  endfunction

  function automatic exp_t e_addiwr();
    exp_t e = '0;
    e.regwrite = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_trap();
    exp_t e = '0;
    e.illegal = 1'b1;
    return e;
  endfunction

  function automatic exp_t got();
    exp_t g;
    g.memread  = bus.memread;
    g.memwrite = bus.memwrite;
    g.iord     = bus.iord;
    g.irwrite  = bus.irwrite;
    g.alusrca  = bus.alusrca;
    g.alusrcb  = bus.alusrcb;
    g.aluop    = bus.aluop;
    g.pcsource = bus.pcsource;
    g.pcen     = bus.pcen;
    g.regwrite = bus.regwrite;
    g.regdst   = bus.regdst;
    g.memtoreg = bus.memtoreg;
    g.illegal  = bus.illegal;
    return g;
  endfunction

  task automatic check(string nm, exp_t e);
    exp_t g;
    g = got();
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (mr mw iord irw[4] asa asb[2] aop[2] pcs[2] pcen rw rdst m2r ill)",
               nm, g, e);
    end
  endtask

  // Inputs are applied just after the active edge, outputs sampled on the falling edge.
  task automatic step(string nm, logic [5:0] o, logic z, exp_t e);
    bus.op   = o;
    bus.zero = z;
    @(negedge clk);
    check(nm, e);
    @(posedge clk);
    #1;
  endtask

  task automatic push(string nm, logic [5:0] o, logic z, exp_t e);
    vec_t v;
    v.name = nm;
    v.op   = o;
    v.zero = z;
    v.exp  = e;
    tbl.push_back(v);
  endtask

  task automatic push_fetch_dec(string nm, logic [5:0] o, logic z);
    for (int b = 0; b < 4; b++) push($sformatf("%s_fetch%0d", nm, b), o, z, e_fetch(b));
    push({nm, "_decode"}, o, z, e_dec());
  endtask

  task automatic fetch_dec_seq(string nm, logic [5:0] o);
    for (int b = 0; b < 4; b++) step($sformatf("%s_fetch%0d", nm, b), o, 1'b0, e_fetch(b));
    step({nm, "_decode"}, o, 1'b0, e_dec());
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.op   = 6'b000000;
    bus.zero = 1'b0;

    // R-type: 7 cycles, regwrite+regdst only in cycle 7
    push_fetch_dec("rtype", 6'b000000, 1'b1);
    push("rtype_rtex", 6'b000000, 1'b1, e_rtex());
    push("rtype_rtwr", 6'b000000, 1'b1, e_rtwr());
    // LB: 8 cycles
    push_fetch_dec("lb", 6'b100000, 1'b0);
    push("lb_memadr", 6'b100000, 1'b0, e_memadr());
    push("lb_lbrd",   6'b100000, 1'b0, e_lbrd());
    push("lb_lbwr",   6'b100000, 1'b0, e_lbwr());
    // SB: 7 cycles, never regwrite
    push_fetch_dec("sb", 6'b101000, 1'b1);
    push("sb_memadr", 6'b101000, 1'b1, e_memadr());
    push("sb_sbwr",   6'b101000, 1'b1, e_sbwr());
    // ADDI: 7 cycles
    push_fetch_dec("addi", 6'b001000, 1'b0);
    push("addi_ex", 6'b001000, 1'b0, e_memadr());
    push("addi_wr", 6'b001000, 1'b0, e_addiwr());
    // BEQ taken / not taken: 6 cycles each
    push_fetch_dec("beq_t", 6'b000100, 1'b1);
    push("beq_t_ex", 6'b000100, 1'b1, e_beqex(1'b1));
    push_fetch_dec("beq_n", 6'b000100, 1'b0);
    push("beq_n_ex", 6'b000100, 1'b0, e_beqex(1'b0));
    // J: 6 cycles
    push_fetch_dec("j", 6'b000010, 1'b0);
    push("j_ex", 6'b000010, 1'b0, e_jex());
`ifndef ILLEGAL_TRAP_EN
    // unknown opcode is a 5-cycle NOP
    push_fetch_dec("nop", 6'b111111, 1'b0);
    push("nop_back_fetch0", 6'b000000, 1'b0, e_fetch(0));
    push("nop_back_fetch1", 6'b000000, 1'b0, e_fetch(1));
    push("nop_back_fetch2", 6'b000000, 1'b0, e_fetch(2));
    push("nop_back_fetch3", 6'b000000, 1'b0, e_fetch(3));
    push("nop_back_decode", 6'b000000, 1'b0, e_dec());
    push("nop_back_rtex",   6'b000000, 1'b0, e_rtex());
    push("nop_back_rtwr",   6'b000000, 1'b0, e_rtwr());
`endif

    // reset held for three checked cycles, outputs all zero
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step($sformatf("reset_hold%0d", i), 6'b000000, 1'b1, '0);
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i].name, tbl[i].op, tbl[i].zero, tbl[i].exp);

    // reset during RTEX: no regwrite, restart at beat 0
    fetch_dec_seq("rst_rt", 6'b000000);
    reset = 1'b1;
    step("rst_in_rtex", 6'b000000, 1'b0, '0);
    reset = 1'b0;
    step("rst_rt_restart0", 6'b000000, 1'b0, e_fetch(0));
    step("rst_rt_restart1", 6'b000000, 1'b0, e_fetch(1));

    // reset mid-fetch clears the beat counter
    step("rst_fb_fetch2", 6'b000000, 1'b0, e_fetch(2));
    reset = 1'b1;
    step("rst_in_fetch3", 6'b000000, 1'b0, '0);
    reset = 1'b0;
    fetch_dec_seq("rst_fb", 6'b001000);
    step("rst_fb_addiex", 6'b001000, 1'b0, e_memadr());
    step("rst_fb_addiwr", 6'b001000, 1'b0, e_addiwr());

`ifdef ILLEGAL_TRAP_EN
    // unknown opcode traps and holds regardless of later op changes
    fetch_dec_seq("trap", 6'b111111);
    for (int i = 0; i < 22; i++)
      step($sformatf("trap_hold%0d", i), (i < 11) ? 6'b111111 : 6'b000000, i[0], e_trap());
    reset = 1'b1;
    step("trap_reset", 6'b000000, 1'b0, '0);
    reset = 1'b0;
    step("trap_exit_fetch0", 6'b000000, 1'b0, e_fetch(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
